// File: rtl/q_rotary_enc_multi.sv
// q_rotary_enc_multi: multi-channel quadrature decoder with input filtering, index latch and velocity
module q_rotary_enc_multi #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 32,
    parameter int FLT_LEN    = 4,
    parameter int VEL_PERIOD = 100000,
    parameter int VEL_W      = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ena,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       A,
    input  logic [CHANNELS-1:0]       B,
    input  logic [CHANNELS-1:0]       Z,
    output logic [CHANNELS*CNT_W-1:0] counter,
    output logic [CHANNELS*CNT_W-1:0] index_pos,
    output logic [CHANNELS-1:0]       index_valid,
    output logic [CHANNELS*VEL_W-1:0] velocity,
    output logic                      vel_strobe,
    output logic [CHANNELS-1:0]       error
);
    localparam int NS = 3 * CHANNELS;
    localparam int TW = $clog2(VEL_PERIOD);
    localparam int XW = CNT_W > VEL_W ? CNT_W : VEL_W;
    localparam logic [7:0] FLT_TOP = 8'(FLT_LEN - 1);
    localparam logic signed [XW-1:0] VMAX = {{(XW-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
    localparam logic signed [XW-1:0] VMIN = ~VMAX;

    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    logic [NS-1:0] s1_q, s1_d, s2_q, s2_d, f_q, f_d;
    logic [7:0]    fc_q [NS];
    logic [7:0]    fc_d [NS];
    logic [TW-1:0] tmr_q, tmr_d;
    logic          vs_q, vs_d, term;

    assign term       = tmr_q == TW'(VEL_PERIOD - 1);
    assign vel_strobe = vs_q;

    // Synchronise and debounce every raw A/B/Z bit; run the shared velocity period timer
    always_comb begin
        s1_d = {Z, B, A};
        s2_d = s1_q;
        f_d  = f_q;
        fc_d = fc_q;
        for (int j = 0; j < NS; j++) begin
            f_d[j]  = (s2_q[j] != f_q[j] && fc_q[j] == FLT_TOP) ? s2_q[j] : f_q[j];
            fc_d[j] = (s2_q[j] == f_q[j] || fc_q[j] == FLT_TOP) ? 8'd0 : fc_q[j] + 8'd1;
        end
        tmr_d = term ? '0 : tmr_q + TW'(1);
        vs_d  = term;
    end

    // Shared input-stage and timer registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            f_q   <= '0;
            fc_q  <= '{default: '0};
            tmr_q <= '0;
            vs_q  <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            f_q   <= f_d;
            fc_q  <= fc_d;
            tmr_q <= tmr_d;
            vs_q  <= vs_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]            cur, step, old_q, old_d;
        logic                  zold_q, zold_d, err_q, err_d, iv_q, iv_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d, ip_q, ip_d, snap_q, snap_d, delta;
        logic signed [XW-1:0]  dx;
        logic [VEL_W-1:0]      vel_q, vel_d;

        // Decode the Gray step and apply count/index/velocity updates, with clr overriding all but velocity
        always_comb begin
            cur    = dir[i] ? {f_q[i], f_q[CHANNELS+i]} : {f_q[CHANNELS+i], f_q[i]};
            step   = gray2bin(cur) - gray2bin(old_q);
            old_d  = cur;
            zold_d = f_q[2*CHANNELS+i];
            delta  = cnt_q - snap_q;
            dx     = XW'(signed'(delta));
            cnt_d  = clr[i] ? '0 : !ena ? cnt_q : step == 2'd1 ? cnt_q + CNT_W'(1)
                   : step == 2'd3 ? cnt_q - CNT_W'(1) : cnt_q;
            err_d  = !clr[i] && (err_q || (ena && step == 2'd2));
            ip_d   = clr[i] ? '0 : (zold_d && !zold_q) ? cnt_q : ip_q;
            iv_d   = !clr[i] && (iv_q || (zold_d && !zold_q));
            snap_d = clr[i] ? '0 : term ? cnt_q : snap_q;
            vel_d  = !term ? vel_q : dx > VMAX ? VMAX[VEL_W-1:0] : dx < VMIN ? VMIN[VEL_W-1:0] : dx[VEL_W-1:0];
        end

        // Per-channel state registers
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                old_q  <= '0;
                zold_q <= 1'b0;
                err_q  <= 1'b0;
                iv_q   <= 1'b0;
                cnt_q  <= '0;
                ip_q   <= '0;
                snap_q <= '0;
                vel_q  <= '0;
            end else begin
                old_q  <= old_d;
                zold_q <= zold_d;
                err_q  <= err_d;
                iv_q   <= iv_d;
                cnt_q  <= cnt_d;
                ip_q   <= ip_d;
                snap_q <= snap_d;
                vel_q  <= vel_d;
            end
        end

        assign counter[i*CNT_W +: CNT_W]   = cnt_q;
        assign index_pos[i*CNT_W +: CNT_W] = ip_q;
        assign velocity[i*VEL_W +: VEL_W]  = vel_q;
        assign index_valid[i]              = iv_q;
        assign error[i]                    = err_q;
    end
endmodule

// File: doc/q_rotary_enc_multi.md
# q_rotary_enc_multi

Multi-channel quadrature encoder interface. Each channel synchronises and debounces its raw A/B/Z sensor inputs, then decodes the 2-bit Gray sequence into a signed position counter with a sticky error flag. It also latches the position on the index pulse and reports per-channel velocity as the count delta over a fixed sample period. It sits between the encoder input pins (after the optocouplers) and the register/bus interface of the motor-control subsystem.

## Interface
Parameters:
- CHANNELS, 4, number of independent encoder channels (1..16)
- CNT_W, 32, position counter width in bits, signed, two's complement
- FLT_LEN, 4, consecutive stable cycles a synchronised input must hold before it is accepted (1..255)
- VEL_PERIOD, 100000, velocity sample period in clock cycles (≥ 2)
- VEL_W, 16, velocity output width in bits, signed, saturating

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- ena  in  1  global count enable
- clr  in  CHANNELS  per-channel synchronous clear of counter, error, index and velocity snapshot
- dir  in  CHANNELS  per-channel count direction: 0 = direct, 1 = reverse (A/B swapped)
- A, B, Z  in  CHANNELS each  raw asynchronous encoder signals
- counter  out  CHANNELS*CNT_W  position; channel i occupies bits [i*CNT_W +: CNT_W]
- index_pos  out  CHANNELS*CNT_W  position latched at the last index rising edge
- index_valid  out  CHANNELS  sticky flag: index_pos has been loaded since the last clear
- velocity  out  CHANNELS*VEL_W  count delta over the last completed period
- vel_strobe  out  1  one-cycle pulse when all velocity outputs update
- error  out  CHANNELS  sticky flag for an illegal A/B transition

## Operation
- Input stage, per signal: 2-FF synchroniser, then a stability filter. The filtered value takes the synchronised value only after FLT_LEN consecutive equal samples. A pulse on the synchronised signal shorter than FLT_LEN cycles is discarded.
- Code: cur = dir ? {A_f,B_f} : {B_f,A_f}. old holds the previous cur and updates every cycle, regardless of ena.
- Increment transitions: 00→01→11→10→00. Decrement transitions are the reverse sequence.
- Illegal transition: both bits change in one cycle. The counter holds and error is set. error stays set until clr[i] or reset.
- Counting and error setting happen only while ena=1. While ena=0, filters and old keep tracking, so re-enabling produces no spurious count.
- Counter wraps modulo 2^CNT_W: max+1 → min, min−1 → max.
- Index: on a rising edge of filtered Z, index_pos ← the counter register value at that cycle (before that cycle's update), and index_valid ← 1. This is independent of ena.
- Velocity:
  - A shared period timer counts 0..VEL_PERIOD−1.
  - At terminal count, for each channel: delta = counter − snap, computed modulo 2^CNT_W and read as signed. velocity ← delta saturated to the VEL_W signed range. snap ← counter. vel_strobe pulses for one cycle.
- Priority, per channel: reset_n=0 > clr[i] > count/index/velocity updates.
  - clr[i] zeroes that channel's counter, error, index_pos, index_valid and snap. It does not touch velocity or the timer.
  - clr coinciding with a count or index edge: the clear wins and the edge is lost.
  - clr coinciding with the velocity terminal: velocity takes the pre-clear delta, then snap is cleared to 0.

## Timing
- Reset values: counter, index_pos, velocity = 0; index_valid, error, vel_strobe = 0. Filters, old, synchronisers, snap and timer are also 0.
- First vel_strobe comes VEL_PERIOD cycles after reset_n deasserts, then every VEL_PERIOD cycles.
- Latency: a raw input change first sampled at edge k gives filtered value at edge k+FLT_LEN+1. counter, error and index_pos are visible after edge k+FLT_LEN+2.
- Maximum trackable edge rate: one filtered transition per FLT_LEN+1 cycles per signal.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with inputs toggling → all outputs 0. First vel_strobe arrives exactly VEL_PERIOD cycles after release.
- Count and direction: 10 forward Gray steps on ch0 with dir=0 → counter=10. Same steps with dir=1 → −10. Step latency equals FLT_LEN+2.
- Glitch and error: an A pulse of FLT_LEN−1 cycles → no count. A and B toggled in the same cycle → error=1 and counter unchanged. error stays set until clr.
- Wrap and saturation: CNT_W=8; 127 then +1 step → −128. VEL_W=4 with 20 steps in one period → velocity=7; 20 reverse steps → −8.
- Index: Z rising when counter=5 → index_pos=5, index_valid=1. clr coinciding with a count step → counter=0 and index_valid=0.
- ena and multichannel: ena=0 during 4 steps, then ena=1 → counter unchanged, no error. Simultaneous distinct step streams on all channels → each counter independently correct.
